// File: rtl/traffic_light_param.sv
// Parametrised single-approach traffic light: green, blink-off/on pairs, yellow, red,
// plus an emergency flashing-yellow mode. Define TL_REMAIN_OUT_EN to add the remain output.
module traffic_light_param #(
    parameter int CNT_W     = 12,
    parameter int G_CYC     = 1024,
    parameter int BLINK_CYC = 128,
    parameter int BLINK_N   = 2,
    parameter int Y_CYC     = 512,
    parameter int R_CYC     = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pass,
    input  logic       flash,
    output logic       R,
    output logic       G,
    output logic       Y,
    output logic [2:0] phase
`ifdef TL_REMAIN_OUT_EN
    ,
    output logic [CNT_W-1:0] remain
`endif
);

    typedef enum logic [2:0] {
        GREEN = 3'd0,
        BOFF  = 3'd1,
        BON   = 3'd2,
        YEL   = 3'd3,
        RED   = 3'd4,
        FOFF  = 3'd5,
        FON   = 3'd6
    } state_e;

    localparam int BIDX_W = (BLINK_N < 2) ? 1 : $clog2(BLINK_N + 1);

    localparam logic [CNT_W-1:0] G_LAST = CNT_W'(G_CYC - 1);
    localparam logic [CNT_W-1:0] B_LAST = CNT_W'(BLINK_CYC - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(Y_CYC - 1);
    localparam logic [CNT_W-1:0] R_LAST = CNT_W'(R_CYC - 1);
    // With BLINK_N == 0 this value is never reached because GREEN skips the blink pairs.
    localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(BLINK_N - 1);

    state_e            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [BIDX_W-1:0] bidx, bidx_nxt;
    logic [CNT_W-1:0]  last;
    logic              terminal;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= GREEN;
            cnt   <= '0;
            bidx  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            bidx  <= bidx_nxt;
        end
    end

    always_comb begin
        case (state)
            BOFF, BON, FOFF, FON: last = B_LAST;
            YEL:                  last = Y_LAST;
            RED:                  last = R_LAST;
            default:              last = G_LAST;
        endcase
    end

    assign terminal = (cnt == last);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        bidx_nxt  = bidx;

        if (flash) begin
            if (state == FON || state == FOFF) begin
                if (terminal) begin
                    state_nxt = (state == FON) ? FOFF : FON;
                    cnt_nxt   = '0;
                end
            end else begin
                state_nxt = FON;
                cnt_nxt   = '0;
            end
        end else if (state == FON || state == FOFF) begin
            // Leaving an emergency always goes through a full red phase.
            state_nxt = RED;
            cnt_nxt   = '0;
        end else if (pass && state != GREEN) begin
            state_nxt = GREEN;
            cnt_nxt   = '0;
            bidx_nxt  = '0;
        end else if (terminal) begin
            cnt_nxt = '0;
            case (state)
                GREEN: begin
                    bidx_nxt  = '0;
                    state_nxt = (BLINK_N == 0) ? YEL : BOFF;
                end
                BOFF: state_nxt = BON;
                BON: begin
                    if (bidx == BIDX_LAST) begin
                        state_nxt = YEL;
                    end else begin
                        state_nxt = BOFF;
                        bidx_nxt  = bidx + BIDX_W'(1);
                    end
                end
                YEL: state_nxt = RED;
                RED: begin
                    state_nxt = GREEN;
                    bidx_nxt  = '0;
                end
                default: state_nxt = GREEN;
            endcase
        end
    end

    assign G     = (state == GREEN) || (state == BON);
    assign Y     = (state == YEL) || (state == FON);
    assign R     = (state == RED);
    assign phase = state;

`ifdef TL_REMAIN_OUT_EN
    assign remain = last - cnt;
`endif

endmodule

// File: tb/tb_traffic_light_param.sv
// Directed bench for traffic_light_param: a default-parameter instance and a
// short-timing instance (BLINK_N=0, G=4, Y=2, R=3, CNT_W=3).
module tb_traffic_light_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, pass, flash;
    logic       r, g, y;
    logic [2:0] phase;
    logic       rst_s, pass_s, flash_s;
    logic       r_s, g_s, y_s;
    logic [2:0] phase_s;
`ifdef TL_REMAIN_OUT_EN
    logic [11:0] remain;
    logic [2:0]  remain_s;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int edge_n      = 0;
    int base, base2, f, gstart, rstart, g2;

    traffic_light_param dut (
        .clk   (clk),
        .rst   (rst),
        .pass  (pass),
        .flash (flash),
        .R     (r),
        .G     (g),
        .Y     (y),
        .phase (phase)
`ifdef TL_REMAIN_OUT_EN
        ,
        .remain(remain)
`endif
    );

    traffic_light_param #(
        .CNT_W    (3),
        .G_CYC    (4),
        .BLINK_CYC(2),
        .BLINK_N  (0),
        .Y_CYC    (2),
        .R_CYC    (3)
    ) dut_s (
        .clk   (clk),
        .rst   (rst_s),
        .pass  (pass_s),
        .flash (flash_s),
        .R     (r_s),
        .G     (g_s),
        .Y     (y_s),
        .phase (phase_s)
`ifdef TL_REMAIN_OUT_EN
        ,
        .remain(remain_s)
`endif
    );

    // Expected {R,G,Y} for each phase code.
    function automatic logic [2:0] lamps_of(input logic [2:0] ph);
        case (ph)
            3'd0, 3'd2: return 3'b010;
            3'd3, 3'd6: return 3'b001;
            3'd4:       return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [2:0] ph_got,
                         input logic [2:0] rgy_got, input logic [2:0] ph_exp);
        logic [5:0] got, exp;
        got = {ph_got, rgy_got};
        exp = {ph_exp, lamps_of(ph_exp)};
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s @edge %0d: observed phase=%0d RGY=%b, expected phase=%0d RGY=%b",
                   tag, edge_n, ph_got, rgy_got, ph_exp, lamps_of(ph_exp));
        end
    endtask

    task automatic chk(input string tag, input logic [2:0] ph_exp);
        check(tag, phase, {r, g, y}, ph_exp);
    endtask

    task automatic chk_s(input string tag, input logic [2:0] ph_exp);
        check(tag, phase_s, {r_s, g_s, y_s}, ph_exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int k);
        while (edge_n < k) tick();
    endtask

    logic [2:0] small_seq [9];
    int         seq_edge  [15];
    logic [2:0] seq_ph    [15];

    initial begin
        small_seq = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4};
        seq_edge  = '{0, 1023, 1024, 1151, 1152, 1279, 1280, 1407, 1408, 1535,
                      1536, 2047, 2048, 3071, 3072};
        seq_ph    = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd1, 3'd1, 3'd2, 3'd2,
                      3'd3, 3'd3, 3'd4, 3'd4, 3'd0};

        rst = 1'b0; pass = 1'b0; flash = 1'b0;
        rst_s = 1'b0; pass_s = 1'b0; flash_s = 1'b0;
        #2;
        chk("reset_state", 3'd0);
        chk_s("reset_state_small", 3'd0);

        // Short-timing instance runs two full cycles while the main one is held in reset.
        @(negedge clk);
        rst_s  = 1'b1;
        edge_n = 0;
        for (int k = 0; k < 18; k++) begin
            chk_s($sformatf("small_seq_%0d", k), small_seq[k % 9]);
            tick();
        end
        chk("held_in_reset", 3'd0);

        @(negedge clk);
        rst    = 1'b1;
        edge_n = 0;
        for (int i = 0; i < 15; i++) begin
            run_to(seq_edge[i]);
            chk($sformatf("normal_%0d", seq_edge[i]), seq_ph[i]);
        end

        // pass held through most of GREEN has no effect.
        base = 3072;
        run_to(base + 100);
        pass = 1'b1;
        run_to(base + 500);
        chk("pass_in_green_mid", 3'd0);
        run_to(base + 901);
        pass = 1'b0;
        run_to(base + 1023);
        chk("pass_in_green_last", 3'd0);
        run_to(base + 1024);
        chk("pass_in_green_boff", 3'd1);

        // One-cycle pass during RED returns to a fresh GREEN.
        run_to(base + 2500);
        chk("red_before_pass", 3'd4);
        pass = 1'b1;
        tick();
        pass = 1'b0;
        chk("pass_in_red", 3'd0);
        base2 = base + 2501;
        run_to(base2 + 1023);
        chk("after_pass_green_last", 3'd0);
        run_to(base2 + 1024);
        chk("after_pass_boff", 3'd1);

        // Flash during YEL for 600 cycles.
        f = base2 + 1600;
        run_to(f);
        chk("yel_before_flash", 3'd3);
        flash = 1'b1;
        tick();
        chk("flash_enter_fon", 3'd6);
        run_to(f + 128);
        chk("fon_last", 3'd6);
        run_to(f + 129);
        chk("foff_first", 3'd5);
        run_to(f + 256);
        chk("foff_last", 3'd5);
        run_to(f + 257);
        chk("fon_2", 3'd6);
        run_to(f + 385);
        chk("foff_2", 3'd5);
        run_to(f + 513);
        chk("fon_3", 3'd6);
        run_to(f + 600);
        chk("fon_before_drop", 3'd6);
        flash = 1'b0;
        tick();
        chk("flash_exit_red", 3'd4);
        run_to(f + 1624);
        chk("flash_red_last", 3'd4);
        run_to(f + 1625);
        chk("flash_red_to_green", 3'd0);

        // flash and pass together during BON: flash wins, pass ignored.
        gstart = f + 1625;
        run_to(gstart + 1200);
        chk("bon_before_flash_pass", 3'd2);
        flash = 1'b1;
        pass  = 1'b1;
        tick();
        chk("flash_pass_fon", 3'd6);
        run_to(gstart + 1210);
        chk("flash_pass_held", 3'd6);
        pass = 1'b0;
        run_to(gstart + 1220);
        chk("flash_only_held", 3'd6);
        flash = 1'b0;
        tick();
        chk("flash_pass_exit_red", 3'd4);
        rstart = gstart + 1221;
        run_to(rstart + 1024);
        chk("red_to_green_2", 3'd0);

        // Asynchronous reset between edges during YEL.
        g2 = rstart + 1024;
        run_to(g2 + 1700);
        chk("yel_before_reset", 3'd3);
        #3;
        rst = 1'b0;
        #1;
        chk("async_reset_mid_yel", 3'd0);
        @(negedge clk);
        chk("reset_held", 3'd0);
        rst    = 1'b1;
        edge_n = 0;
        run_to(1023);
        chk("post_reset_green_last", 3'd0);
        run_to(1024);
        chk("post_reset_boff", 3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
